vga_scanout: RTL and testbench
==============================

// Module: vga_scanout
// PURPOSE
//  Display scan-out stage directly downstream of the video RAM. Generates VGA raster timing
//  and fetches one framebuffer byte per pixel clock from VRAM (20-bit byte address, read data
//  registered on negedge, so data is back one clk after the address). Decodes RGB332 bytes to
//  colour outputs. Framebuffer is (H_ACTIVE>>SCALE_SHIFT) x (V_ACTIVE>>SCALE_SHIFT) bytes at fb_base.
// PARAMETERS
//  H_ACTIVE 640 visible pixels/line;   H_FP 16;  H_SYNC 96;  H_BP 48  (H_TOTAL = sum = 800)
//  V_ACTIVE 480 visible lines/frame;   V_FP 10;  V_SYNC 2;   V_BP 33  (V_TOTAL = sum = 525)
//  SCALE_SHIFT 1  pixel/line replication = 2**SCALE_SHIFT in both axes; FB_WIDTH = H_ACTIVE>>SCALE_SHIFT
// PORTS
//  clk           in   1   pixel clock
//  rst           in   1   synchronous, active-high reset
//  enable        in   1   scan-out enable, sampled at frame start
//  fb_base       in   20  framebuffer base byte address, sampled at frame start
//  vram_address  out  20  VRAM read address (this block never writes VRAM)
//  vram_r_data   in   8   VRAM read data, valid 1 clk after vram_address
//  hsync         out  1   horizontal sync, active low
//  vsync         out  1   vertical sync, active low
//  de            out  1   data enable, high on visible pixels
//  red/green/blue out 3/3/2  colour = vram byte [7:5]/[4:2]/[1:0]; 0 when de=0
//  frame_start   out  1   1-clk pulse with the output for pixel (h=0,v=0)
//  vblank        out  1   high while output-aligned v >= V_ACTIVE
// BEHAVIOUR
//  - Reset: h_cnt=v_cnt=0, vram_address=0, hsync=vsync=1, de=0, rgb=0, frame_start=0,
//    vblank=0, shadow fb_base=0, shadow enable=0. Reset mid-frame: all of the above next clk,
//    pipeline flushed, raster restarts at (0,0).
//  - Counters: h_cnt 0..H_TOTAL-1; at wrap h_cnt->0 and v_cnt increments, v_cnt 0..V_TOTAL-1 wraps to 0.
//  - Frame start (h_cnt=0,v_cnt=0): load shadow fb_base and shadow enable; they hold for whole frame.
//  - Stage 0 (counters) -> stage 1 (vram_address registered) -> stage 2 (vram_r_data captured,
//    decoded). hsync/vsync/de/vblank/frame_start are delayed 2 clks to stay aligned with colour.
//  - Address for visible (h,v): fb_base_shadow + (v>>S)*FB_WIDTH + (h>>S), modulo 2**20.
//    Line base kept incrementally (+FB_WIDTH every 2**S lines); no multiplier.
//  - Outside visible area, or shadow enable=0: vram_address holds last value, de=0, rgb=0.
//    Timing (syncs, vblank, frame_start) always runs regardless of enable.
//  - hsync low when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync likewise on v.
//  - Changing enable/fb_base mid-frame has no effect until the next frame start.
//  - Address wrap: crossing 0xFFFFF continues at 0x00000, no error flag.
// TESTING
//  1. rst 4 clks, fb_base=0, enable=1, VRAM[i]=i -> frame_start at clk 2 after release; line 0 outputs
//     bytes 0,0,1,1,2,2...; pixel h=2 gives red=0 green=0 blue=1; byte 0xE3 gives r=7 g=0 b=3.
//  2. Run 2 frames -> frame_start period 420000 clks; hsync low 96 clks from output h=656;
//     vsync low exactly 2 lines (v=490,491); de high 640 clks per visible line, 480 lines.
//  3. Line addressing -> visible lines v=0,1 read 0..319; v=2,3 read 320..639; v=479 ends at 76799.
//  4. fb_base 0 -> 0x10000 at v=100 -> rest of frame unchanged; next frame first address 0x10000.
//  5. fb_base=0xFFF00 -> line 0 addresses 0xFFF00..0xFFFFF then 0x00000..0x0003F.
//  6. rst pulsed at h=300,v=100 -> next clk de=0, hsync=vsync=1, vram_address=0; frame_start
//     2 clks after release; enable=0 frame -> de=0, rgb=0 while syncs keep toggling.

Source files
------------

// File: rtl/vga_scanout_if.sv
// vga_scanout_if: the bus between the scan-out stage and its surroundings.
//   VRAM side : vram_address (20b byte address), vram_r_data (8b, 1 clk later)
//   Video side: hsync/vsync (active low), de, red/green/blue (3/3/2),
//               frame_start (1-clk pulse with pixel 0,0), vblank
// Modports:
//   master - the scan-out block (drives address and video, takes read data)
//   slave  - VRAM / display sink (drives read data, observes the rest)
interface vga_scanout_if;
  logic [19:0] vram_address;
  logic [7:0]  vram_r_data;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [2:0]  red;
  logic [2:0]  green;
  logic [1:0]  blue;
  logic        frame_start;
  logic        vblank;

  modport master (
    output vram_address, hsync, vsync, de, red, green, blue, frame_start, vblank,
    input  vram_r_data
  );

  modport slave (
    input  vram_address, hsync, vsync, de, red, green, blue, frame_start, vblank,
    output vram_r_data
  );
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout: VGA raster generator and framebuffer scan-out.
// Fetches one RGB332 byte per pixel clock from VRAM and decodes it to colour.
// The framebuffer is (H_ACTIVE>>SCALE_SHIFT) x (V_ACTIVE>>SCALE_SHIFT) bytes
// at a base address sampled once per frame; each byte is replicated
// 2**SCALE_SHIFT times in both axes.
// Ports:
//   clk, rst    - pixel clock, synchronous active-high reset
//   enable_i    - scan-out enable, sampled at frame start
//   fb_base_i   - framebuffer base byte address, sampled at frame start
//   bus         - vga_scanout_if.master (VRAM read port + video outputs)
// Pipeline: stage 0 counters -> stage 1 vram_address -> stage 2 colour
// capture; sync/de/vblank/frame_start ride two register stages alongside.
module vga_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable_i,
  input  logic [19:0]  fb_base_i,
  vga_scanout_if.master bus
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_WIDTH = H_ACTIVE >> SCALE_SHIFT;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_GRP_MASK = VW'((1 << SCALE_SHIFT) - 1);
  localparam logic [19:0]   FB_STEP    = 20'(FB_WIDTH);

  typedef struct packed {
    logic hs;   // active low
    logic vs;   // active low
    logic vis;  // visible pixel with scan-out enabled
    logic vb;
    logic fs;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0, vb: 1'b0, fs: 1'b0};

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [19:0]   off_q, off_d;     // (v>>S)*FB_WIDTH, kept incrementally
  logic [19:0]   base_q;           // frame shadow of fb_base_i
  logic          en_q;             // frame shadow of enable_i
  logic [19:0]   addr_q, addr_d;
  logic          frame0;
  logic [19:0]   base_eff;
  logic          en_eff;
  ctl_t          ctl0, ctl1_q, ctl2_q;
  logic [7:0]    rgb_q;

  always_comb begin
    frame0 = (h_q == '0) && (v_q == '0);
    // The shadow registers load on the same edge that registers the address
    // for pixel (0,0), so that pixel must bypass them.
    base_eff = frame0 ? fb_base_i : base_q;
    en_eff   = frame0 ? enable_i  : en_q;

    h_d   = h_q + HW'(1);
    v_d   = v_q;
    off_d = off_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d   = '0;
        off_d = '0;
      end else begin
        v_d = v_q + VW'(1);
        // Advance one framebuffer row after each group of replicated lines.
        if (((v_q + VW'(1)) & V_GRP_MASK) == '0) off_d = off_q + FB_STEP;
      end
    end

    ctl0.hs  = !((h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END));
    ctl0.vs  = !((v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END));
    ctl0.vis = (h_q < H_VIS_END) && (v_q < V_VIS_END) && en_eff;
    ctl0.vb  = (v_q >= V_VIS_END);
    ctl0.fs  = frame0;

    // Address wraps naturally at 20 bits; it holds outside fetch slots.
    addr_d = ctl0.vis ? (base_eff + off_q + 20'(h_q >> SCALE_SHIFT)) : addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q    <= '0;
      v_q    <= '0;
      off_q  <= '0;
      base_q <= '0;
      en_q   <= 1'b0;
      addr_q <= '0;
      ctl1_q <= CTL_IDLE;
      ctl2_q <= CTL_IDLE;
      rgb_q  <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      off_q  <= off_d;
      if (frame0) begin
        base_q <= fb_base_i;
        en_q   <= enable_i;
      end
      addr_q <= addr_d;
      ctl1_q <= ctl0;
      ctl2_q <= ctl1_q;
      rgb_q  <= ctl1_q.vis ? bus.vram_r_data : 8'h00;
    end
  end

  assign bus.vram_address = addr_q;
  assign bus.hsync        = ctl2_q.hs;
  assign bus.vsync        = ctl2_q.vs;
  assign bus.de           = ctl2_q.vis;
  assign bus.vblank       = ctl2_q.vb;
  assign bus.frame_start  = ctl2_q.fs;
  assign bus.red          = rgb_q[7:5];
  assign bus.green        = rgb_q[4:2];
  assign bus.blue         = rgb_q[1:0];
endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a reduced raster (80x30 totals) so that
// many whole frames fit in a short run. A reference model derives (h,v) from
// the cycle count since reset and pushes expected address / video words; a
// negedge monitor pops and compares them when they fall due.
module tb_vga_scanout;
  localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 24, VFP = 2, VS = 2, VBP = 2;
  localparam int S  = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FBW = HA >> S;
  localparam int FRAME = HT * VT;

  typedef struct { longint due; logic [19:0] addr; } aexp_t;
  typedef struct { longint due; logic [12:0] vid; } vexp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [19:0] fb_base = '0;
  vga_scanout_if vif ();

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SCALE_SHIFT(S)
  ) dut (
    .clk(clk), .rst(rst), .enable_i(enable), .fb_base_i(fb_base), .bus(vif)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:1048575];
  always @(negedge clk) vif.vram_r_data <= mem[vif.vram_address];

  longint pc = 0;
  logic   rst_seen = 1'b0;
  always @(posedge clk) begin
    pc       <= pc + 1;
    rst_seen <= rst;
  end

  aexp_t aq[$];
  vexp_t vq[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [12:0] vid_now();
    return {vif.hsync, vif.vsync, vif.de, vif.red, vif.green, vif.blue,
            vif.frame_start, vif.vblank};
  endfunction

  // Monitor
  always @(negedge clk) begin
    aexp_t a;
    vexp_t v;
    if (rst_seen) begin
      checks++;
      if (vif.vram_address !== 20'h0 || vid_now() !== 13'b1_1_0_00000000_0_0) begin
        errors++;
        $display("FAIL reset_state pc=%0d got addr=%h vid=%b want addr=00000 vid=%b",
                 pc, vif.vram_address, vid_now(), 13'b1_1_0_00000000_0_0);
      end
    end else begin
      while (aq.size() > 0 && aq[0].due < pc) void'(aq.pop_front());
      while (vq.size() > 0 && vq[0].due < pc) void'(vq.pop_front());
      if (aq.size() > 0 && aq[0].due == pc) begin
        a = aq.pop_front();
        checks++;
        if (vif.vram_address !== a.addr) begin
          errors++;
          if (errors < 30)
            $display("FAIL vram_address pc=%0d got %h want %h", pc, vif.vram_address, a.addr);
        end
      end
      if (vq.size() > 0 && vq[0].due == pc) begin
        v = vq.pop_front();
        checks++;
        if (vid_now() !== v.vid) begin
          errors++;
          if (errors < 30)
            $display("FAIL video pc=%0d got {hs,vs,de,rgb,fs,vb}=%b want %b", pc, vid_now(), v.vid);
        end
      end
    end
  end

  // Reference model state
  longint      t = 0;
  logic [19:0] m_base = '0;
  logic        m_en = 1'b0;
  logic [19:0] m_addr = '0;

  task automatic step();
    int h, v;
    logic vis, hs_n, vs_n;
    logic [7:0] px;
    h = int'(t % HT);
    v = int'((t / HT) % VT);
    if (h == 0 && v == 0) begin
      m_base = fb_base;
      m_en   = enable;
    end
    vis = (h < HA) && (v < VA) && m_en;
    if (vis) m_addr = 20'(m_base + (v >> S) * FBW + (h >> S));
    hs_n = !(h >= HA + HFP && h < HA + HFP + HS);
    vs_n = !(v >= VA + VFP && v < VA + VFP + VS);
    px   = vis ? mem[m_addr] : 8'h00;
    aq.push_back('{pc + 1, m_addr});
    vq.push_back('{pc + 2, {hs_n, vs_n, vis, px, (h == 0 && v == 0), (v >= VA)}});
    @(posedge clk);
    @(negedge clk);
    t++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    aq.delete();
    vq.delete();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst    = 1'b0;
    t      = 0;
    m_addr = '0;
  endtask

  initial begin
    for (int i = 0; i < 1048576; i++) mem[i] = 8'($urandom);
    mem[2] = 8'hE3;  // exercises r=7 g=0 b=3 on line 0
    fb_base = 20'h00000;
    enable  = 1'b1;
    @(negedge clk);
    do_reset(4);

    // Frame 0: base changes at v=10, must not affect this frame
    run(10 * HT);
    fb_base = 20'h10000;
    run(FRAME - 10 * HT);
    // Frame 1 picks up 0x10000
    run(FRAME);
    // Frame 2: address wrap across 0xFFFFF
    fb_base = 20'hFFF00;
    run(FRAME);
    // Frame 3: disabled, syncs keep running
    enable  = 1'b0;
    fb_base = 20'($urandom);
    run(FRAME);
    // Frame 4: reset mid-frame at h=30, v=10
    enable = 1'b1;
    run(10 * HT + 30);
    do_reset(2);
    fb_base = 20'($urandom);
    run(FRAME);
    // Randomised enable/base churn across several frames
    for (int k = 0; k < 60; k++) begin
      fb_base = 20'($urandom);
      enable  = ($urandom % 4) != 0;
      run(100 + int'($urandom % 50));
    end
    run(FRAME);

    // Drain outstanding expectations
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (aq.size() != 0 || vq.size() != 0) begin
      errors++;
      $display("FAIL drain got addr_q=%0d vid_q=%0d pending want 0", aq.size(), vq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
